// File: rtl/key_note_select_pkg.sv
// Shared types and the 10 MHz note divider table for the key/note selection front end.
package synth_pkg;
    localparam logic [17:0] NOTE_DIV [13] = '{38223, 36078, 34052, 32141, 30337, 28635, 27027,
                                             25511, 24079, 22727, 21452, 20248, 19111};

    typedef logic [3:0] note_idx_t;

    typedef enum logic {IDLE, PLAYING} sel_state_t;
endpackage

// File: rtl/key_note_select_if.sv
// Raw key/button inputs and registered oscillator controls of key_note_select.
interface key_note_select_if #(parameter int NUM_KEYS = 13);
    import synth_pkg::*;

    logic [NUM_KEYS-1:0] keys;
    logic                oct_up;
    logic                oct_dn;
    logic [17:0]         divider;
    logic                enable;
    logic [1:0]          octve_dwn;
    note_idx_t           note_idx;
    logic                new_note;

    modport master (output keys, oct_up, oct_dn,
                    input  divider, enable, octve_dwn, note_idx, new_note);
    modport slave  (input  keys, oct_up, oct_dn,
                    output divider, enable, octve_dwn, note_idx, new_note);
endinterface

// File: rtl/key_note_select_debouncer.sv
// Two-flop synchroniser plus stability counter; stable follows the synced level once it
// has differed for DEBOUNCE_CYCLES consecutive cycles. rise pulses the cycle stable goes 1.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic nRst,
    input  logic raw,
    output logic stable,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            // Any cycle where the synced level matches stable restarts the count.
            if (sync[1] != stable) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable <= sync[1];
                    rise   <= sync[1];
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/key_note_select.sv
// Debounces note keys and octave buttons, picks the active note, registers oscillator controls.
// Optional LAST_KEY_PRIORITY_EN: most recently pressed key wins instead of lowest index.
module key_note_select
    import synth_pkg::*;
#(
    parameter int NUM_KEYS        = 13,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input logic clk,
    input logic nRst,
    key_note_select_if.slave bus
);
    logic [NUM_KEYS-1:0] held, key_rise;
    logic                up_st, dn_st, up_rise, dn_rise;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk(clk), .nRst(nRst), .raw(bus.keys[i]), .stable(held[i]), .rise(key_rise[i]));
    end

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .nRst(nRst), .raw(bus.oct_up), .stable(up_st), .rise(up_rise));
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk(clk), .nRst(nRst), .raw(bus.oct_dn), .stable(dn_st), .rise(dn_rise));

    logic       any_held;
    note_idx_t  low_held, sel_c;

    assign any_held = |held;

    always_comb begin
        low_held = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (held[i]) low_held = note_idx_t'(i);
    end

`ifdef LAST_KEY_PRIORITY_EN
    note_idx_t low_rise, last_key;

    always_comb begin
        low_rise = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (key_rise[i]) low_rise = note_idx_t'(i);
    end

    // A fresh press wins; otherwise keep last_key while held, else fall back to lowest held.
    always_comb begin
        if (|key_rise)          sel_c = low_rise;
        else if (held[last_key]) sel_c = last_key;
        else                    sel_c = low_held;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)         last_key <= '0;
        else if (any_held) last_key <= sel_c;
    end
`else
    assign sel_c = low_held;
`endif

    sel_state_t state_q, state_d;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_held)  state_d = PLAYING;
            PLAYING: if (!any_held) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic [17:0] divider_q;
    logic        enable_q, new_note_q;
    logic [1:0]  oct_q;
    note_idx_t   note_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            divider_q  <= '0;
            enable_q   <= 1'b0;
            note_q     <= '0;
            new_note_q <= 1'b0;
        end else if (state_d == PLAYING) begin
            divider_q  <= NOTE_DIV[sel_c];
            enable_q   <= 1'b1;
            note_q     <= sel_c;
            new_note_q <= (state_q == IDLE) || (sel_c != note_q);
        end else begin
            divider_q  <= '0;
            enable_q   <= 1'b0;
            note_q     <= '0;
            new_note_q <= 1'b0;
        end
    end

    // Simultaneous up/down presses cancel.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)                                      oct_q <= '0;
        else if (dn_rise && !up_rise && oct_q != 2'd3)  oct_q <= oct_q + 2'd1;
        else if (up_rise && !dn_rise && oct_q != 2'd0)  oct_q <= oct_q - 2'd1;
    end

    assign bus.divider   = divider_q;
    assign bus.enable    = enable_q;
    assign bus.note_idx  = note_q;
    assign bus.new_note  = new_note_q;
    assign bus.octve_dwn = oct_q;
endmodule

// File: tb/tb_key_note_select.sv
// Directed bench for key_note_select with DEBOUNCE_CYCLES=4 (raw edge -> output in 7 edges).
module tb_key_note_select;
    localparam int NK = 13;
    localparam int D  = 4;
    localparam int LAT = D + 3;

    logic clk = 1'b0;
    logic nRst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #50 clk = ~clk;

    key_note_select_if #(.NUM_KEYS(NK)) bus ();

    key_note_select #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .nRst(nRst), .bus(bus));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_note(input string tag, input int en, input int idx, input int div, input int nn);
        check({tag, ".enable"},   32'(bus.enable),   32'(en));
        check({tag, ".note_idx"}, 32'(bus.note_idx), 32'(idx));
        check({tag, ".divider"},  32'(bus.divider),  32'(div));
        check({tag, ".new_note"}, 32'(bus.new_note), 32'(nn));
    endtask

    task automatic press_oct(input logic up, input logic dn, input int exp);
        bus.oct_up = up;
        bus.oct_dn = dn;
        tick(LAT);
        check("octave", 32'(bus.octve_dwn), 32'(exp));
        bus.oct_up = 1'b0;
        bus.oct_dn = 1'b0;
        tick(LAT);
    endtask

    initial begin
        bus.keys   = '0;
        bus.oct_up = 1'b0;
        bus.oct_dn = 1'b0;

        // Reset held while keys toggle
        for (int i = 0; i < 10; i++) begin
            bus.keys = (i % 2 == 0) ? 13'h1FFF : 13'h0000;
            tick(1);
        end
        check_note("reset", 0, 0, 0, 0);
        check("reset.octve_dwn", 32'(bus.octve_dwn), 32'd0);
        bus.keys = '0;
        tick(1);
        nRst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("post_reset.new_note", 32'(bus.new_note), 32'd0);
            check("post_reset.enable",   32'(bus.enable),   32'd0);
        end

        // Single key 9
        bus.keys[9] = 1'b1;
        tick(LAT - 1);
        check("k9.early_enable", 32'(bus.enable), 32'd0);
        tick(1);
        check_note("k9.on", 1, 9, 22727, 1);
        tick(1);
        check_note("k9.hold", 1, 9, 22727, 0);
        bus.keys[9] = 1'b0;
        tick(LAT - 1);
        check("k9.rel_early", 32'(bus.enable), 32'd1);
        tick(1);
        check_note("k9.off", 0, 0, 0, 0);

        // Bounce on key 0, then held
        for (int i = 0; i < 10; i++) begin
            bus.keys[0] = ~bus.keys[0];
            tick(2);
            check("bounce.enable", 32'(bus.enable), 32'd0);
        end
        bus.keys[0] = 1'b1;
        tick(LAT - 1);
        check("bounce.early", 32'(bus.enable), 32'd0);
        tick(1);
        check_note("bounce.on", 1, 0, 38223, 1);
        bus.keys[0] = 1'b0;
        tick(LAT);
        check_note("bounce.off", 0, 0, 0, 0);

`ifdef LAST_KEY_PRIORITY_EN
        bus.keys[3] = 1'b1;
        tick(LAT);
        check_note("lk.k3", 1, 3, 32141, 1);
        bus.keys[12] = 1'b1;
        tick(LAT);
        check_note("lk.k12", 1, 12, 19111, 1);
        tick(1);
        check("lk.k12_pulse_end", 32'(bus.new_note), 32'd0);
        bus.keys[12] = 1'b0;
        tick(LAT);
        check_note("lk.back3", 1, 3, 32141, 1);
`else
        bus.keys[12] = 1'b1;
        tick(LAT);
        check_note("pri.k12", 1, 12, 19111, 1);
        bus.keys[3] = 1'b1;
        tick(LAT);
        check_note("pri.k3", 1, 3, 32141, 1);
        tick(1);
        check("pri.k3_pulse_end", 32'(bus.new_note), 32'd0);
        bus.keys[3] = 1'b0;
        tick(LAT);
        check_note("pri.back12", 1, 12, 19111, 1);
`endif
        bus.keys = '0;
        tick(LAT);
        check_note("pri.idle", 0, 0, 0, 0);

        // Two keys rising together: lowest index in both modes
        bus.keys[5] = 1'b1;
        bus.keys[7] = 1'b1;
        tick(LAT);
        check_note("simul", 1, 5, 28635, 1);
        bus.keys = '0;
        tick(LAT);
        check_note("simul.idle", 0, 0, 0, 0);

        // Octave control
        press_oct(1'b0, 1'b1, 1);
        press_oct(1'b0, 1'b1, 2);
        press_oct(1'b0, 1'b1, 3);
        press_oct(1'b0, 1'b1, 3);
        press_oct(1'b1, 1'b1, 3);
        press_oct(1'b1, 1'b0, 2);
        press_oct(1'b1, 1'b0, 1);
        press_oct(1'b1, 1'b0, 0);
        press_oct(1'b1, 1'b0, 0);
        press_oct(1'b0, 1'b1, 1);

        // Reset mid-note
        bus.keys[9] = 1'b1;
        tick(LAT);
        check_note("mid.on", 1, 9, 22727, 1);
        #10 nRst = 1'b0;
        #1;
        check_note("mid.reset", 0, 0, 0, 0);
        check("mid.reset.octve_dwn", 32'(bus.octve_dwn), 32'd0);
        bus.keys = '0;
        tick(2);
        nRst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("mid.release.new_note", 32'(bus.new_note), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
